// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP adder arbiter.
//   FP_W    : operand / result width (IEEE-754 single)
//   TMO_DEF : default per-phase handshake timeout in cycles
//   state_t : arbiter FSM state encoding
package fp_add_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned TMO_DEF = 64;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StWaitZ = 3'd3,
        StResp  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter.
//   clk, rst : clock, async active-high reset (requester 0 has priority after reset)
//   req      : NREQ-wide request vector
//   en       : commit the current grant and advance the priority pointer
//   gnt      : one-hot grant (combinational), zero when no request
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    localparam int unsigned IW = $clog2(NREQ);

    // ptr_q is the index searched first on the next arbitration.
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
        ptr_d = ptr_q;
        if (en && found) begin
            ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Arbitrates NREQ requesters onto one shared handshaked FP adder, one operation in flight.
//   req_valid/req_a/req_b : per-requester request and operands (held until req_ready)
//   req_ready             : one-cycle one-hot grant pulse
//   rsp_valid/rsp_data    : one-hot result valid to the granted requester, sum A+B
//   rsp_ack               : granted requester consumes the result
//   err                   : one-cycle pulse when an adder handshake phase times out
//   add_*                 : strobe/ack handshake to the shared adder; add_idle parks it
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned TMO  = TMO_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]      rsp_data,
    input  logic [NREQ-1:0]      rsp_ack,
    output logic                 err,
    output logic [FP_W-1:0]      add_a,
    output logic [FP_W-1:0]      add_b,
    output logic                 add_a_stb,
    output logic                 add_b_stb,
    input  logic                 add_a_ack,
    input  logic                 add_b_ack,
    input  logic [FP_W-1:0]      add_z,
    input  logic                 add_z_stb,
    output logic                 add_z_ack,
    output logic                 add_idle
);

    localparam int unsigned CW = $clog2(TMO) + 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic [NREQ-1:0] gnt;
    logic [FP_W-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            arb_en;
    logic            tmo_hit;

    assign arb_en  = (state_q == StIdle) && (|req_valid);
    // Last allowed cycle of a phase; without a handshake now the phase has used TMO cycles.
    assign tmo_hit = (cnt_q == CW'(TMO - 1));

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .clk(clk),
        .rst(rst),
        .req(req_valid),
        .en (arb_en),
        .gnt(gnt)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ready_d = '0;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_en) begin
                    grant_d = gnt;
                    ready_d = gnt;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            a_d = req_a[i*FP_W +: FP_W];
                            b_d = req_b[i*FP_W +: FP_W];
                        end
                    end
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                if (add_a_ack) begin
                    state_d = StLoadB;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    grant_d = '0;
                    err_d   = 1'b1;
                end
            end
            StLoadB: begin
                if (add_b_ack) begin
                    state_d = StWaitZ;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    grant_d = '0;
                    err_d   = 1'b1;
                end
            end
            StWaitZ: begin
                if (add_z_stb) begin
                    z_d     = add_z;
                    state_d = StResp;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    grant_d = '0;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                // Only the granted requester's ack retires the result.
                if (|(rsp_ack & grant_q)) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {StLoadA, StLoadB, StWaitZ}) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ready_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from registers so an async reset clears them immediately.
    assign req_ready = ready_q;
    assign rsp_valid = (state_q == StResp) ? grant_q : '0;
    assign rsp_data  = z_q;
    assign err       = err_q;
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_a_stb = (state_q == StLoadA);
    assign add_b_stb = (state_q == StLoadB);
    assign add_z_ack = (state_q == StWaitZ);
    assign add_idle  = (state_q == StIdle) || (state_q == StResp);

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_data;
    logic [NREQ-1:0]   rsp_ack = '0;
    logic              err;
    logic [31:0]       add_a, add_b;
    logic              add_a_stb, add_b_stb;
    logic              add_a_ack = 1'b0;
    logic              add_b_ack = 1'b0;
    logic [31:0]       add_z = '0;
    logic              add_z_stb = 1'b0;
    logic              add_z_ack;
    logic              add_idle;

    fp_add_arbiter #(
        .NREQ(NREQ),
        .TMO (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_ack  (rsp_ack),
        .err      (err),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_a_stb(add_a_stb),
        .add_b_stb(add_b_stb),
        .add_a_ack(add_a_ack),
        .add_b_ack(add_b_ack),
        .add_z    (add_z),
        .add_z_stb(add_z_stb),
        .add_z_ack(add_z_ack),
        .add_idle (add_idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exact conversions for small non-negative integers (< 2^24).
    function automatic logic [31:0] int_to_fp(input int unsigned n);
        int          p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int k = 0; k < 32; k++) if (n[k]) p = k;
        m = (n << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int unsigned fp_to_int(input logic [31:0] f);
        int          e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h0, 1'b1, f[22:0]};
        return m >> (23 - e);
    endfunction

    // ---------------- adder model state ----------------
    logic [31:0] m_a, m_b;
    bit          m_pend, m_zreal;
    int          m_zdly;
    bit          s_a_stb, s_b_stb, s_z_ack;
    logic [31:0] s_a, s_b;
    bit          ack_rand, stall_z, noise_en, noise_force;
    int          zdly_fixed;

    // ---------------- requester engine state ----------------
    logic [31:0] job_a [NREQ][16];
    logic [31:0] job_b [NREQ][16];
    logic [31:0] job_e [NREQ][16];
    int          job_cnt [NREQ];
    int          job_ptr [NREQ];
    int          r_st [NREQ];     // 0 idle, 1 requesting, 2 awaiting result, 3 acking
    int          gap [NREQ];
    int          ackd [NREQ];
    int          ack_dly_fixed;
    int          last;            // last granted requester in the reference model
    int          grant_log[$];

    task automatic reset_bench_state();
        m_pend = 0; m_zreal = 0; m_zdly = 0;
        s_a_stb = 0; s_b_stb = 0; s_z_ack = 0; s_a = '0; s_b = '0;
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; add_z = '0;
        req_valid = '0; rsp_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            r_st[i] = 0; gap[i] = 0; ackd[i] = 0;
        end
        last = NREQ - 1;
    endtask

    task automatic clear_jobs();
        for (int i = 0; i < NREQ; i++) begin
            job_cnt[i] = 0; job_ptr[i] = 0; r_st[i] = 0; gap[i] = 0;
        end
        grant_log.delete();
    endtask

    task automatic add_job(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e);
        job_a[i][job_cnt[i]] = a;
        job_b[i][job_cnt[i]] = b;
        job_e[i][job_cnt[i]] = e;
        job_cnt[i]++;
    endtask

    task automatic adder_step();
        // Handshakes completed at the preceding rising edge.
        if (s_a_stb && add_a_ack) m_a = s_a;
        if (s_b_stb && add_b_ack) begin
            m_b     = s_b;
            m_pend  = 1;
            m_zreal = 0;
            m_zdly  = (zdly_fixed >= 0) ? zdly_fixed : int'($urandom_range(0, 4));
        end
        if (s_z_ack && add_z_stb && m_zreal) begin
            m_pend  = 0;
            m_zreal = 0;
        end
        // Arbiter parked without taking the result: it gave up on this operation.
        if (add_idle && m_pend) begin
            m_pend  = 0;
            m_zreal = 0;
        end
        s_a_stb = add_a_stb; s_a = add_a;
        s_b_stb = add_b_stb; s_b = add_b;
        s_z_ack = add_z_ack;
        add_a_ack = ack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        add_b_ack = ack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (m_pend && !stall_z) begin
            if (m_zdly > 0) begin
                m_zdly--;
                add_z_stb = 0;
                add_z     = $urandom;
            end else begin
                add_z_stb = 1;
                add_z     = int_to_fp(fp_to_int(m_a) + fp_to_int(m_b));
                m_zreal   = 1;
            end
        end else if (noise_force || (noise_en && add_idle && $urandom_range(0, 1) == 1)) begin
            add_z_stb = 1;
            add_z     = $urandom;
        end else begin
            add_z_stb = 0;
        end
    endtask

    task automatic req_step();
        logic [NREQ-1:0] prev_valid;
        int              exp_w, j;
        prev_valid = req_valid;
        for (int i = 0; i < NREQ; i++) begin
            check("stray_ready", 32'(req_ready[i] && r_st[i] != 1), 32'd0);
            check("stray_rsp_valid", 32'(rsp_valid[i] && r_st[i] != 2), 32'd0);
            case (r_st[i])
                0: if (job_ptr[i] < job_cnt[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        req_valid[i]       = 1'b1;
                        req_a[i*32 +: 32]  = job_a[i][job_ptr[i]];
                        req_b[i*32 +: 32]  = job_b[i][job_ptr[i]];
                        r_st[i]            = 1;
                    end
                end
                1: if (req_ready[i]) begin
                    // Reference: first requester valid at the grant edge, searching after last.
                    exp_w = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        j = (last + k) % NREQ;
                        if (exp_w < 0 && prev_valid[j]) exp_w = j;
                    end
                    check("rr_grant", 32'(i), 32'(exp_w));
                    last = i;
                    grant_log.push_back(i);
                    req_valid[i] = 1'b0;
                    req_a[i*32 +: 32] = $urandom;
                    req_b[i*32 +: 32] = $urandom;
                    ackd[i] = ack_rand ? int'($urandom_range(0, 3)) : ack_dly_fixed;
                    r_st[i] = 2;
                end
                2: if (rsp_valid[i]) begin
                    check("rsp_data", rsp_data, job_e[i][job_ptr[i]]);
                    if (ackd[i] > 0) begin
                        ackd[i]--;
                    end else begin
                        rsp_ack[i] = 1'b1;
                        r_st[i]    = 3;
                    end
                end
                default: begin
                    rsp_ack[i] = 1'b0;
                    job_ptr[i]++;
                    gap[i]  = ack_rand ? int'($urandom_range(0, 2)) : 0;
                    r_st[i] = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst) begin
            reset_bench_state();
        end else begin
            adder_step();
            req_step();
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NREQ; i++) begin
            if (r_st[i] != 0 || job_ptr[i] < job_cnt[i]) return 0;
        end
        return 1;
    endfunction

    task automatic run_until_done(input int bound);
        int c;
        c = 0;
        while (!all_done() && c < bound) begin
            step();
            c++;
        end
        check("done_within_bound", 32'(all_done()), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  rsp_data, 32'd0);
        check({tag, "_err"},       32'(err), 32'd0);
        check({tag, "_add_a_stb"}, 32'(add_a_stb), 32'd0);
        check({tag, "_add_b_stb"}, 32'(add_b_stb), 32'd0);
        check({tag, "_add_z_ack"}, 32'(add_z_ack), 32'd0);
        check({tag, "_add_idle"},  32'(add_idle), 32'd1);
        check({tag, "_add_a"},     add_a, 32'd0);
        check({tag, "_add_b"},     add_b, 32'd0);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  zc;
        bit  seen;
        int unsigned x, y;
        int  idx;

        vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        vecs[1] = '{1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
        vecs[2] = '{2, 32'h4120_0000, 32'h41A0_0000, 32'h41F0_0000};
        vecs[3] = '{1, 32'h42C8_0000, 32'h3F80_0000, 32'h42CA_0000};
        vecs[4] = '{0, 32'h0000_0000, 32'h40A0_0000, 32'h40A0_0000};
        vecs[5] = '{2, 32'h447A_0000, 32'h447A_0000, 32'h44FA_0000};

        ack_rand = 0; stall_z = 0; noise_en = 0; noise_force = 0;
        zdly_fixed = 0; ack_dly_fixed = 0;
        reset_bench_state();
        clear_jobs();

        // Power-on reset.
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        step();
        step();
        rst = 1'b0;

        // Directed single-operation vectors.
        for (int v = 0; v < 6; v++) begin
            clear_jobs();
            add_job(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].e);
            run_until_done(100);
            check("vec_grant_count", 32'(grant_log.size()), 32'd1);
            if (grant_log.size() > 0) check("vec_grant_idx", 32'(grant_log[0]), 32'(vecs[v].idx));
        end

        // Adder strobing a result while the arbiter is idle must be ignored.
        noise_force = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("idle_noise_rsp_data", rsp_data, 32'h44FA_0000);
            check("idle_noise_z_ack", 32'(add_z_ack), 32'd0);
            check("idle_noise_add_idle", 32'(add_idle), 32'd1);
        end
        // Same noise during LOAD and a held RESP.
        ack_dly_fixed = 3;
        clear_jobs();
        add_job(1, int_to_fp(6), int_to_fp(7), int_to_fp(13));
        run_until_done(100);
        noise_force = 0;
        ack_dly_fixed = 0;

        // Three simultaneous requesters after reset: grants 0,1,2.
        rst = 1'b1; step(); rst = 1'b0;
        clear_jobs();
        for (int i = 0; i < NREQ; i++) add_job(i, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        run_until_done(200);
        check("all3_count", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++) check("all3_order", 32'(grant_log[i]), 32'(i));

        // req1 back-to-back with req2 pending: grants 1,2,1.
        rst = 1'b1; step(); rst = 1'b0;
        clear_jobs();
        add_job(1, int_to_fp(1), int_to_fp(2), int_to_fp(3));
        add_job(1, int_to_fp(4), int_to_fp(5), int_to_fp(9));
        add_job(2, int_to_fp(8), int_to_fp(8), int_to_fp(16));
        run_until_done(200);
        check("fair_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("fair_0", 32'(grant_log[0]), 32'd1);
            check("fair_1", 32'(grant_log[1]), 32'd2);
            check("fair_2", 32'(grant_log[2]), 32'd1);
        end

        // Result never arrives: timeout after TMO cycles in WAIT_Z.
        clear_jobs();
        stall_z = 1;
        add_job(0, int_to_fp(7), int_to_fp(8), int_to_fp(15));
        zc = 0; seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            if (err) seen = 1;
            else if (add_z_ack) zc++;
            check("tmo_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("tmo_err_seen", 32'(seen), 32'd1);
        check("tmo_cycles", 32'(zc), 32'(TMO));
        check("tmo_add_idle", 32'(add_idle), 32'd1);
        check("tmo_z_ack", 32'(add_z_ack), 32'd0);
        clear_jobs();
        stall_z = 0;
        step();
        check("tmo_err_pulse", 32'(err), 32'd0);
        check("tmo_idle_after", 32'(add_idle), 32'd1);

        // Async reset while waiting for the adder result.
        clear_jobs();
        zdly_fixed = 20;
        add_job(0, int_to_fp(3), int_to_fp(4), int_to_fp(7));
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            step();
            if (add_z_ack) seen = 1;
        end
        check("wz_reached", 32'(seen), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        step();
        step();
        rst = 1'b0;
        zdly_fixed = 0;
        clear_jobs();
        add_job(2, int_to_fp(11), int_to_fp(12), int_to_fp(23));
        add_job(0, int_to_fp(30), int_to_fp(12), int_to_fp(42));
        run_until_done(200);
        check("postrst_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("postrst_first", 32'(grant_log[0]), 32'd0);
            check("postrst_second", 32'(grant_log[1]), 32'd2);
        end

        // Randomized traffic with random adder stalls, ack delays and idle noise.
        ack_rand = 1; noise_en = 1; zdly_fixed = -1;
        for (int bt = 0; bt < 3; bt++) begin
            clear_jobs();
            for (int n = 0; n < 10; n++) begin
                x   = $urandom_range(0, 5000);
                y   = $urandom_range(0, 5000);
                idx = int'($urandom_range(0, NREQ - 1));
                add_job(idx, int_to_fp(x), int_to_fp(y), int_to_fp(x + y));
            end
            run_until_done(3000);
            check("rand_grant_count", 32'(grant_log.size()), 32'd10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
